fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the CPU, directly upstream of the instruction memory.
- Owns the program counter and drives the byte address into the instruction memory.
- Takes back the combinationally returned 32-bit instruction and captures it with its PC into the IF/ID pipeline register for decode.
- Handles stall, flush, branch and jump redirects.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word placed in IF/ID when it holds no valid instruction.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hazard stall; hold PC and IF/ID contents.
- flush  input  1  squash the instruction being captured into IF/ID.
- branch_taken  input  1  redirect PC to branch_target.
- branch_target  input  32  byte address of the branch destination.
- jump  input  1  redirect PC to jump_target.
- jump_target  input  32  byte address of the jump destination.
- imem_pc  output  32  byte address to instruction memory (word index = imem_pc>>2).
- imem_instr  input  32  instruction word returned combinationally for imem_pc.
- ifid_instr  output  32  registered instruction to decode.
- ifid_pc  output  32  registered PC of ifid_instr.
- ifid_pc_plus4  output  32  registered ifid_pc+4.
- ifid_valid  output  1  ifid_instr is a real instruction.
- fetch_count  output  32  count of instructions captured valid into IF/ID.

Behaviour:
- Timing
  - One clock, all state updates on rising clk edge; rst sampled synchronously.
  - imem_pc is driven directly from the PC register; no combinational path from any input to imem_pc.
  - Fetch latency: imem_instr is sampled in the same cycle imem_pc is presented and appears on ifid_* one edge later.
- Reset (rst=1 at an edge, overrides all other inputs, including mid-stall or mid-redirect):
  - PC=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_pc_plus4=0, ifid_valid=0, fetch_count=0.
- Next-PC priority, highest first:
  - jump -> jump_target.
  - branch_taken -> branch_target.
  - stall -> hold PC.
  - else -> PC+4.
  - Redirects beat stall; a redirect is never lost.
- PC arithmetic is modulo 2^32: PC=32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
- IF/ID update, highest first:
  - flush=1 -> ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc and ifid_pc_plus4 hold. Applies even if stall=1.
  - Else stall=1 -> all ifid_* hold.
  - Else capture: ifid_instr=imem_instr, ifid_pc=PC, ifid_pc_plus4=PC+4 (mod 2^32), ifid_valid=1.
- Upstream convention: the upstream unit asserts flush together with jump/branch_taken. This block does not infer flush from a redirect.
- fetch_count:
  - Increments by 1 on each edge where IF/ID performs a capture (not on reset, flush or stall edges).
  - Wraps from 32'hFFFF_FFFF to 0.
- First cycle out of reset: imem_pc=RESET_PC; that instruction appears at ifid_* after the next edge.

Optional Feature:
- Macro FETCH_ALIGN_CHECK_EN.
- Defined:
  - Adds output align_fault (1 bit, reset 0).
  - A selected redirect target with bits[1:0]!=0 is not loaded; PC holds instead.
  - align_fault sets on that edge and stays set until rst.
  - While align_fault=1, the PC holds and IF/ID performs no captures (ifid_valid forced 0 at each non-stall edge).
- Undefined:
  - No align_fault port.
  - Redirect targets are loaded with bits[1:0] forced to 2'b00.
  - Fetch continues normally.

Test Plan:
- Reset then free-run 4 edges with imem returning 32'hA0+(pc>>2):
  - imem_pc goes 0,4,8,C.
  - ifid_pc goes 0,4,8 with ifid_instr A0,A1,A2.
  - ifid_valid=1 from the 2nd edge.
  - fetch_count=3.
- Stall for 2 cycles at PC=8:
  - imem_pc stays 8 and ifid_* hold.
  - fetch_count is unchanged.
  - Release -> ifid_pc=8 next edge.
- branch_taken=1, target 32'h40, flush=1 at PC=C:
  - Next edge: imem_pc=40, ifid_valid=0, ifid_instr=NOP_INSTR.
  - Following edge: ifid_pc=40.
- jump=1 (target 32'h100) with branch_taken=1 (target 32'h40) and stall=1 on the same edge -> imem_pc=100.
- PC=32'hFFFF_FFFC, free-run -> next imem_pc=0 and ifid_pc_plus4=0.
- rst asserted during stall with PC=20 -> next edge PC=RESET_PC, ifid_valid=0, fetch_count=0.
- Branch target 32'h42:
  - With FETCH_ALIGN_CHECK_EN: align_fault=1, PC holds.
  - Without FETCH_ALIGN_CHECK_EN: PC=32'h40.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage. Owns the program counter, presents it to the
// instruction memory as a byte address, and captures the combinationally
// returned instruction together with its PC into the IF/ID pipeline register.
// Handles stall, flush, and branch/jump redirects.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   : misaligned redirect targets are refused, the PC holds, and a
//               sticky align_fault output is raised that also blocks captures.
//   undefined : redirect targets are loaded with bits[1:0] cleared.
//
// Ports
//   clk            in   1   rising-edge clock
//   rst            in   1   synchronous active-high reset
//   stall          in   1   hold PC and IF/ID
//   flush          in   1   squash the instruction being captured into IF/ID
//   branch_taken   in   1   redirect PC to branch_target
//   branch_target  in  32   branch destination byte address
//   jump           in   1   redirect PC to jump_target (beats branch)
//   jump_target    in  32   jump destination byte address
//   imem_pc        out 32   byte address to instruction memory (from PC reg)
//   imem_instr     in  32   instruction returned combinationally for imem_pc
//   ifid_instr     out 32   registered instruction for decode
//   ifid_pc        out 32   registered PC of ifid_instr
//   ifid_pc_plus4  out 32   registered ifid_pc + 4
//   ifid_valid     out  1   ifid_instr is a real instruction
//   fetch_count    out 32   number of valid captures into IF/ID (wraps)
//   align_fault    out  1   (FETCH_ALIGN_CHECK_EN only) sticky misalign fault
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic [31:0] fetch_count
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        align_fault
`endif
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic        redirect_s;
  logic [31:0] redirect_tgt_s;
  logic [31:0] pc_plus4_s;
  logic        capture_ok_s;

`ifdef FETCH_ALIGN_CHECK_EN
  logic        align_fault_q, align_fault_d;
  logic        misaligned_s;
`endif

  // Next-state logic for the PC and the IF/ID register.
  always_comb begin
    redirect_s = jump | branch_taken;
    // Jump has priority over branch when both are asserted.
    if (jump) begin
      redirect_tgt_s = jump_target;
    end else begin
      redirect_tgt_s = branch_target;
    end
    pc_plus4_s = pc_q + 32'd4;
    pc_d       = pc_q;

`ifdef FETCH_ALIGN_CHECK_EN
    align_fault_d = align_fault_q;
    misaligned_s  = redirect_s && (redirect_tgt_s[1:0] != 2'b00);
    // Once faulted, fetch is frozen until reset.
    if (align_fault_q) begin
      pc_d = pc_q;
    end else if (misaligned_s) begin
      pc_d          = pc_q;
      align_fault_d = 1'b1;
    end else if (redirect_s) begin
      pc_d = redirect_tgt_s;
    end else if (stall) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_plus4_s;
    end
    capture_ok_s = ~align_fault_q;
`else
    // Redirects override stall so they are never lost.
    if (redirect_s) begin
      pc_d = redirect_tgt_s & 32'hFFFF_FFFC;
    end else if (stall) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_plus4_s;
    end
    capture_ok_s = 1'b1;
`endif

    ifid_instr_d    = ifid_instr_q;
    ifid_pc_d       = ifid_pc_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    ifid_valid_d    = ifid_valid_q;
    fetch_count_d   = fetch_count_q;

    // Flush wins over stall; PC fields are kept so decode still sees context.
    if (flush) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
    end else if (stall) begin
      ifid_valid_d = ifid_valid_q;
    end else if (capture_ok_s) begin
      ifid_instr_d    = imem_instr;
      ifid_pc_d       = pc_q;
      ifid_pc_plus4_d = pc_plus4_s;
      ifid_valid_d    = 1'b1;
      fetch_count_d   = fetch_count_q + 32'd1;
    end else begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q            <= RESET_PC;
      ifid_instr_q    <= NOP_INSTR;
      ifid_pc_q       <= 32'h0000_0000;
      ifid_pc_plus4_q <= 32'h0000_0000;
      ifid_valid_q    <= 1'b0;
      fetch_count_q   <= 32'h0000_0000;
`ifdef FETCH_ALIGN_CHECK_EN
      align_fault_q   <= 1'b0;
`endif
    end else begin
      pc_q            <= pc_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_q       <= ifid_pc_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_valid_q    <= ifid_valid_d;
      fetch_count_q   <= fetch_count_d;
`ifdef FETCH_ALIGN_CHECK_EN
      align_fault_q   <= align_fault_d;
`endif
    end
  end

  assign imem_pc       = pc_q;
  assign ifid_instr    = ifid_instr_q;
  assign ifid_pc       = ifid_pc_q;
  assign ifid_pc_plus4 = ifid_pc_plus4_q;
  assign ifid_valid    = ifid_valid_q;
  assign fetch_count   = fetch_count_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign align_fault   = align_fault_q;
`endif

endmodule
